light_phase_guard: RTL
======================

Name: light_phase_guard

Overview:
Safety stage directly downstream of a per-intersection light controller. Takes the controller's combinational per-direction requests and drives the registered light outputs the map sees. Enforces a minimum hold time per phase and an all-Stop clearance interval before any conflicting phase is applied; the clearance extends while the intersection centre is occupied.

Parameters:
MIN_HOLD, 8, cycles a phase is held before a conflicting change is accepted (>=1)
CLEAR_CYCLES, 4, consecutive centre-empty all-Stop cycles before a new conflicting phase (>=1)
CNT_W, 8, width of the hold/clear counters; must hold max(MIN_HOLD, CLEAR_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
reqN  in  3  requested code, northbound traffic
reqS  in  3  requested code, southbound traffic
reqE  in  3  requested code, eastbound traffic
reqW  in  3  requested code, westbound traffic
center  in  4  sensor_light[3:0]; any bit 1 = car inside intersection
outN  out  3  applied code, northbound (registered)
outS  out  3  applied code, southbound (registered)
outE  out  3  applied code, eastbound (registered)
outW  out  3  applied code, westbound (registered)
clearing  out  1  1 while in CLEAR state
phase_cnt  out  16  count of phases applied since reset, wraps at 16'hFFFF->0

Behaviour:
- Codes: Stop=000, Forward_only=001, Left_only=010, Right_only=011, Go=100. Request codes 101-111 normalised to Stop before any comparison.
- Reset (rst=0, asynchronous, any time incl. mid-clearance): out* = Stop, state = CLEAR, clr_cnt=0, hold_cnt=0, phase_cnt=0, clearing=1.
- States: CLEAR, HOLD.
- HOLD: hold_cnt increments each cycle, saturates at MIN_HOLD. Let R = normalised requests, C = current outputs.
  - R == C: stay.
  - Reduction (every direction has R==C or R==Stop, at least one differs): next edge out*=R, hold_cnt=0, phase_cnt+1, stay HOLD; allowed regardless of hold_cnt.
  - Conflicting (any other difference): if hold_cnt==MIN_HOLD, next edge out*=Stop, state=CLEAR, clr_cnt=0; else keep C.
- CLEAR: out* = Stop. clr_cnt increments each cycle with center==0; forced to 0 in any cycle with center!=0. In the cycle clr_cnt==CLEAR_CYCLES-1 and center==0, next edge: out*=R sampled that cycle, state=HOLD, hold_cnt=0, phase_cnt+1. If R is all Stop, still transitions (phase_cnt counts it).
- Net latency for a conflicting change with empty centre: all-Stop visible exactly CLEAR_CYCLES cycles, new phase on the following edge.
- Requests changing during CLEAR: only the value on the exit cycle is used.
- Counters never wrap except phase_cnt.

Optional Feature:
LIGHT_GUARD_DEBUG_EN: when defined, adds output debug_port[29:0] = {phase_cnt[13:0], state(1), clearing(1), clr_cnt[5:0], hold_cnt[7:0]} (counters zero-extended/truncated to field width), registered, reset to 0. When undefined the port does not exist and behaviour is otherwise identical.

Decomposition:
- Shared package light_pkg: the five light-code constants, state encoding (CLEAR=0, HOLD=1), a normalisation function (invalid->Stop) and a reduction-check function.
- One sub-module: phase_timer — saturating up-counter with synchronous clear and enable, instantiated for hold_cnt and clr_cnt.

Test Plan:
- Reset: rst=0 with reqN=Go -> out*=000, clearing=1; release, center=0 -> 4 cycles later outN=100, clearing=0, phase_cnt=1.
- Conflict after hold: outN=Go held 8 cycles, then reqN=Stop, reqE=Go -> out* =000 for exactly 4 cycles, then outE=100, outN=000, phase_cnt+1.
- Early conflict: reqE=Go applied at hold_cnt=3 -> outN stays 100 until hold_cnt=8, then 4-cycle clearance, then outE=100.
- Reduction: outN=outS=Go, hold_cnt=2, reqS=Stop -> next edge outS=000, outN=100, clearing never asserts.
- Busy centre: during CLEAR, center=4'b0010 on clearance cycles 2-5 -> clr_cnt restarts; new phase appears exactly 4 empty cycles after center returns to 0.
- Invalid code: reqW=3'b110, others Stop from outW=Go -> treated as reduction, outW=000 next edge; with LIGHT_GUARD_DEBUG_EN, debug_port fields match internal counters.

Source files
------------

// File: rtl/light_pkg.sv
// Shared light codes, guard state encoding and request-classification helpers
// for the light_phase_guard block.
package light_pkg;

  typedef logic [2:0] light_t;
  // Index 0..3 = N, S, E, W.
  typedef light_t [3:0] lights_t;

  localparam light_t Stop        = 3'b000;
  localparam light_t ForwardOnly = 3'b001;
  localparam light_t LeftOnly    = 3'b010;
  localparam light_t RightOnly   = 3'b011;
  localparam light_t Go          = 3'b100;

  typedef enum logic {
    StClear = 1'b0,
    StHold  = 1'b1
  } state_e;

  function automatic light_t normalise(light_t code);
    return (code > Go) ? Stop : code;
  endfunction

  // True when req differs from cur only by turning some directions to Stop.
  function automatic logic isReduction(lights_t req, lights_t cur);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (req[i] != cur[i] && req[i] != Stop) ok = 1'b0;
    end
    return ok && (req != cur);
  endfunction

endpackage

// File: rtl/light_phase_guard_if.sv
// Request/light bundle between a light controller (master) and the phase guard (slave).
interface light_phase_guard_if;
  import light_pkg::*;

  light_t      reqN;
  light_t      reqS;
  light_t      reqE;
  light_t      reqW;
  logic [3:0]  center;
  light_t      outN;
  light_t      outS;
  light_t      outE;
  light_t      outW;
  logic        clearing;
  logic [15:0] phase_cnt;

  modport master (
    output reqN, reqS, reqE, reqW, center,
    input  outN, outS, outE, outW, clearing, phase_cnt
  );

  modport slave (
    input  reqN, reqS, reqE, reqW, center,
    output outN, outS, outE, outW, clearing, phase_cnt
  );

endinterface

// File: rtl/phase_timer.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module phase_timer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Max   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] countQ, countD;

  always_comb begin
    countD = countQ;
    if (clr) begin
      countD = '0;
    end else if (en && countQ != MaxVal) begin
      countD = countQ + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/light_phase_guard.sv
// Registered light stage enforcing a minimum phase hold and an all-Stop clearance
// before conflicting phases. Optional debug_port enabled by LIGHT_GUARD_DEBUG_EN.
module light_phase_guard
  import light_pkg::*;
#(
  parameter int unsigned MIN_HOLD     = 8,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  light_phase_guard_if.slave  bus
`ifdef LIGHT_GUARD_DEBUG_EN
  ,
  output logic [29:0]         debug_port
`endif
);

  localparam logic [CNT_W-1:0] HoldDone = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] ClearEnd = CNT_W'(CLEAR_CYCLES - 1);

  state_e            stateQ, stateD;
  lights_t           outQ, outD, req;
  logic [15:0]       phaseQ;
  logic [CNT_W-1:0]  holdCnt, clrCnt;
  logic              load;
  logic              holdClr, clrClr;
  logic              centerBusy;

  assign req = {normalise(bus.reqW), normalise(bus.reqE),
                normalise(bus.reqS), normalise(bus.reqN)};
  assign centerBusy = |bus.center;

  always_comb begin
    stateD = stateQ;
    outD   = outQ;
    load   = 1'b0;
    case (stateQ)
      StHold: begin
        if (req != outQ) begin
          if (isReduction(req, outQ)) begin
            outD = req;
            load = 1'b1;
          end else if (holdCnt == HoldDone) begin
            outD   = {4{Stop}};
            stateD = StClear;
          end
        end
      end
      StClear: begin
        outD = {4{Stop}};
        if (!centerBusy && clrCnt == ClearEnd) begin
          outD   = req;
          stateD = StHold;
          load   = 1'b1;
        end
      end
    endcase
  end

  // Hold count restarts on every applied phase and is parked at 0 while clearing.
  assign holdClr = (stateD == StClear) || load;
  // Clear count only runs over consecutive empty-centre cycles inside CLEAR.
  assign clrClr  = (stateQ != StClear) || centerBusy || load;

  phase_timer #(
    .Width (CNT_W),
    .Max   (MIN_HOLD)
  ) u_holdTimer (
    .clk   (clk),
    .rst   (rst),
    .clr   (holdClr),
    .en    (1'b1),
    .count (holdCnt)
  );

  phase_timer #(
    .Width (CNT_W),
    .Max   (CLEAR_CYCLES - 1)
  ) u_clrTimer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clrClr),
    .en    (1'b1),
    .count (clrCnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StClear;
      outQ   <= {4{Stop}};
      phaseQ <= '0;
    end else begin
      stateQ <= stateD;
      outQ   <= outD;
      if (load) phaseQ <= phaseQ + 16'd1;
    end
  end

  assign bus.outN      = outQ[0];
  assign bus.outS      = outQ[1];
  assign bus.outE      = outQ[2];
  assign bus.outW      = outQ[3];
  assign bus.clearing  = (stateQ == StClear);
  assign bus.phase_cnt = phaseQ;

`ifdef LIGHT_GUARD_DEBUG_EN
  logic [29:0] debugQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debugQ <= '0;
    end else begin
      debugQ <= {phaseQ[13:0], stateQ == StHold, stateQ == StClear,
                 6'(clrCnt), 8'(holdCnt)};
    end
  end

  assign debug_port = debugQ;
`endif

endmodule
